seq_magnitude_comparator: RTL and testbench

Multi-cycle magnitude comparator for two WIDTH-bit operands. It walks the operands MSB-first, DIGIT bits per clock, and stops early at the first digit that differs. It reports mutually exclusive GT/ET/LT flags with a start/done handshake. An unsigned/two's-complement mode is selected per operation. It is the parametrised, sequential successor to the team's fixed-width combinational comparators, for use where wide operands must not create a long combinational compare chain.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/seq_magnitude_comparator_digit_compare.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 120 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic gt;
        logic et;
        logic lt;
    } result_t;

    localparam result_t RES_NONE = '{gt: 1'b0, et: 1'b0, lt: 1'b0};
    localparam result_t RES_GT   = '{gt: 1'b1, et: 1'b0, lt: 1'b0};
    localparam result_t RES_ET   = '{gt: 1'b0, et: 1'b1, lt: 1'b0};
    localparam result_t RES_LT   = '{gt: 1'b0, et: 1'b0, lt: 1'b1};

    // Digit counter width; a single-digit operand still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_compare #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt_c,
    output logic             eq_c,
    output logic             lt_c
);

    assign gt_c = (a > b);
    assign eq_c = (a == b);
    assign lt_c = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first
// differing digit; signed mode uses an offset-binary mapping of both operands.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             ET,
    output logic             LT
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);

    generate
        if (DIGIT == 0 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    result_t          res_q, res_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic d_gt, d_eq, d_lt;

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .a    (sa_q[WIDTH-1 -: DIGIT]),
        .b    (sb_q[WIDTH-1 -: DIGIT]),
        .gt_c (d_gt),
        .eq_c (d_eq),
        .lt_c (d_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping both MSBs turns a two's-complement order into an unsigned one.
                    sa_d            = A;
                    sb_d            = B;
                    sa_d[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
                    sb_d[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
                    cnt_d           = '0;
                    busy_d          = 1'b1;
                    state_d         = RUN;
                end
            end
            RUN: begin
                if (d_gt || d_lt) begin
                    res_d   = d_gt ? RES_GT : RES_LT;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (d_eq && cnt_q == CW'(N - 1)) begin
                    res_d   = RES_ET;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    sa_d  = WIDTH'(sa_q << DIGIT);
                    sb_d  = WIDTH'(sb_q << DIGIT);
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign GT   = res_q.gt;
    assign ET   = res_q.et;
    assign LT   = res_q.lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized self-checking bench for seq_magnitude_comparator against an arithmetic reference.
module tb_seq_magnitude_comparator;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 2;
    localparam int unsigned W2 = 8;
    localparam int unsigned D2 = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start, sm, busy, done, gt, et, lt;
    logic [W-1:0]  a, b;
    logic          start2, sm2, busy2, done2, gt2, et2, lt2;
    logic [W2-1:0] a2, b2;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] last_res  = 3'b000;
    logic [2:0] last_res2 = 3'b000;

    seq_magnitude_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .signed_mode(sm),
        .busy(busy), .done(done), .GT(gt), .ET(et), .LT(lt)
    );

    seq_magnitude_comparator #(.WIDTH(W2), .DIGIT(D2)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .signed_mode(sm2),
        .busy(busy2), .done(done2), .GT(gt2), .ET(et2), .LT(lt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {GT,ET,LT} from plain integer ordering of the operands.
    function automatic logic [2:0] ref_res(input logic [31:0] av, input logic [31:0] bv,
                                           input logic smv, input int w);
        longint va, vb;
        va = longint'(av);
        vb = longint'(bv);
        if (smv) begin
            if (va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
            if (vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
        end
        if (va > vb)  return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    // Cycle (after the start edge) in which done appears.
    function automatic int ref_lat(input logic [31:0] av, input logic [31:0] bv,
                                   input int w, input int d);
        logic [31:0] x;
        x = av ^ bv;
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i]) return (w - 1 - i) / d + 2;
        end
        return w / d + 1;
    endfunction

    // Issue one operation on the WIDTH=16 instance; optionally a stray start at cycle inj.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic smv,
                          input int inj);
        int cyc;
        logic bad;
        logic [2:0] er;
        int el;
        er = ref_res(32'(av), 32'(bv), smv, W);
        el = ref_lat(32'(av), 32'(bv), W, D);
        start = 1'b1; a = av; b = bv; sm = smv;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
        cyc = 1;
        bad = 1'b0;
        while (!done && cyc < 40) begin
            if (!busy || {gt, et, lt} !== last_res) bad = 1'b1;
            if (cyc == inj) begin
                start = 1'b1; a = W'(0); b = W'(9); sm = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("run_busy_hold", 32'(bad), 32'(0));
        check("latency", 32'(cyc), 32'(el));
        check("flags", 32'({gt, et, lt}), 32'(er));
        check("busy_at_done", 32'(busy), 32'(0));
        last_res = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_hold", 32'({done, busy, gt, et, lt}), 32'({2'b00, last_res}));
        end
    endtask

    task automatic run_op8(input logic [W2-1:0] av, input logic [W2-1:0] bv, input logic smv);
        int cyc;
        logic [2:0] er;
        er = ref_res(32'(av), 32'(bv), smv, W2);
        start2 = 1'b1; a2 = av; b2 = bv; sm2 = smv;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = W2'($urandom); b2 = W2'($urandom); sm2 = 1'($urandom);
        cyc = 1;
        while (!done2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("n1_latency", 32'(cyc), 32'(ref_lat(32'(av), 32'(bv), W2, D2)));
        check("n1_flags", 32'({gt2, et2, lt2}), 32'(er));
        last_res2 = er;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        start = 1'b0; a = '0; b = '0; sm = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; sm2 = 1'b0;
        rst_n = 1'b0;
        #12;
        check("reset_state", 32'({busy, done, gt, et, lt}), 32'(0));
        check("reset_state_n1", 32'({busy2, done2, gt2, et2, lt2}), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed cases, including back-to-back starts on the done cycle.
        run_op(16'h1234, 16'h1234, 1'b0, 0);
        idle(2);
        run_op(16'h8000, 16'h7FFF, 1'b0, 0);
        run_op(16'h8000, 16'h7FFF, 1'b1, 0);
        idle(1);
        run_op(16'h0001, 16'h0002, 1'b0, 0);
        run_op(16'h0005, 16'h0003, 1'b0, 3);
        idle(4);
        run_op(16'hFFFF, 16'h0001, 1'b1, 0);
        run_op(16'h00F0, 16'h0F00, 1'b1, 0);
        idle(3);

        // Asynchronous reset in the middle of an equal-operand run.
        start = 1'b1; a = 16'h1234; b = 16'h1234; sm = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({busy, done, gt, et, lt}), 32'(0));
        last_res = 3'b000;
        last_res2 = 3'b000;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        idle(12);

        // Randomized operations with biased operand relationships.
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(32'd1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
        end

        // Single-digit instance.
        run_op8(8'hFF, 8'h01, 1'b1);
        run_op8(8'hFF, 8'h01, 1'b0);
        run_op8(8'h5A, 8'h5A, 1'b1);
        for (int i = 0; i < 30; i++) begin
            run_op8(W2'($urandom), W2'($urandom), 1'($urandom));
        end
        @(posedge clk); #1;
        check("n1_idle_hold", 32'({done2, busy2, gt2, et2, lt2}), 32'({2'b00, last_res2}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
